// File: rtl/tone_pkg.sv
// Shared constants, key half-period table and FSM state type for the tone decoder.
package tone_pkg;

  localparam int unsigned NumKeys = 16;
  localparam int unsigned CntW    = 11;

  localparam logic [CntW-1:0] CntMax = 11'd2047;

  // Index 0 is the rightmost entry, so the list reads from key 15 down to key 0.
  localparam logic [NumKeys-1:0][CntW-1:0] ToneTable = {
    11'd166, 11'd177, 11'd198, 11'd222, 11'd236, 11'd264, 11'd296, 11'd332,
    11'd373, 11'd395, 11'd444, 11'd471, 11'd498, 11'd559, 11'd665, 11'd747
  };

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StLocked
  } tone_state_e;

  function automatic logic tone_match(logic [CntW-1:0] h, logic [CntW-1:0] t,
                                      int unsigned tol);
    logic [CntW-1:0] diff;
    diff = (h >= t) ? (h - t) : (t - h);
    return 32'(diff) <= tol;
  endfunction

endpackage

// File: rtl/tone_sync.sv
// Two-flop synchronizer for the asynchronous tone input plus a both-edges detector.
module tone_sync (
  input  logic clk,
  input  logic rst_l,
  input  logic tone_i,
  output logic level_o,
  output logic edge_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tone_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign edge_o  = s2_q ^ s3_q;

endmodule

// File: rtl/tone_decoder.sv
// Tone decoder: measures tone half-periods in ticks and locks onto a matching key.
// Optional half_period output enabled by defining TONE_DECODER_PERIOD_OUT_EN.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned DIV       = 100,
  parameter int unsigned TOL       = 4,
  parameter int unsigned MATCH_CNT = 4,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        tone_in,
`ifdef TONE_DECODER_PERIOD_OUT_EN
  output logic [10:0] half_period,
`endif
  output logic        key_valid,
  output logic [3:0]  key_idx,
  output logic [15:0] keys
);

  localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;

  logic            edge_pulse, level_unused;
  logic [PreW-1:0] pre_q, pre_d;
  logic            tick;
  logic [CntW-1:0] cnt_q, cnt_d;

  tone_state_e     state_q, state_d;
  logic [3:0]      cand_q, cand_d, mcnt_q, mcnt_d;
  logic            cvld_q, cvld_d;
  logic            valid_q, valid_d;
  logic [3:0]      idx_q, idx_d;
  logic [15:0]     keys_q, keys_d;

  logic [NumKeys-1:0] hit_vec;
  logic               hit_any;
  logic [3:0]         hit_idx;
  logic [3:0]         app_cand, app_mcnt;
  logic               app_cvld, app_lock, timeout;

  tone_sync u_sync (
    .clk     (clk),
    .rst_l   (rst_l),
    .tone_i  (tone_in),
    .level_o (level_unused),
    .edge_o  (edge_pulse)
  );

  assign tick  = (pre_q == PreW'(DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  // The tick landing on an edge clock belongs to the new half-period.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_pulse) begin
      cnt_d = tick ? CntW'(1) : '0;
    end else if (tick && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Table spacing exceeds twice the tolerance, so at most one bit of hit_vec is set.
  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int k = 0; k < NumKeys; k++) begin
      hit_vec[k] = tone_match(cnt_q, ToneTable[k], TOL);
      hit_idx    = hit_idx | (hit_vec[k] ? 4'(k) : 4'd0);
    end
  end
  assign hit_any = |hit_vec;
  assign timeout = (cnt_q >= CntW'(TIMEOUT));

  always_comb begin
    app_cand = '0;
    app_cvld = 1'b0;
    app_mcnt = '0;
    if (hit_any) begin
      app_cvld = 1'b1;
      app_cand = hit_idx;
      app_mcnt = (cvld_q && (cand_q == hit_idx)) ? mcnt_q + 1'b1 : 4'd1;
    end
    app_lock = hit_any && (app_mcnt == 4'(MATCH_CNT));
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cvld_d  = cvld_q;
    mcnt_d  = mcnt_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (edge_pulse) begin
      unique case (state_q)
        StIdle: begin
          state_d = StMeasure;
          cand_d  = '0;
          cvld_d  = 1'b0;
          mcnt_d  = '0;
        end
        StMeasure, StLocked: begin
          if (!(state_q == StLocked && hit_any && hit_idx == idx_q)) begin
            cand_d  = app_cand;
            cvld_d  = app_cvld;
            mcnt_d  = app_mcnt;
            state_d = app_lock ? StLocked : StMeasure;
            valid_d = app_lock;
            idx_d   = app_lock ? hit_idx : 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (timeout && (state_q != StIdle)) begin
      state_d = StIdle;
      cand_d  = '0;
      cvld_d  = 1'b0;
      mcnt_d  = '0;
      valid_d = 1'b0;
      idx_d   = '0;
    end
    keys_d = valid_d ? (16'd1 << idx_d) : 16'd0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      state_q <= StIdle;
      cand_q  <= '0;
      cvld_q  <= 1'b0;
      mcnt_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      keys_q  <= '0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cvld_q  <= cvld_d;
      mcnt_q  <= mcnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      keys_q  <= keys_d;
    end
  end

`ifdef TONE_DECODER_PERIOD_OUT_EN
  logic [CntW-1:0] hp_q;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hp_q <= '0;
    end else if (edge_pulse) begin
      hp_q <= cnt_q;
    end
  end
  assign half_period = hp_q;
`endif

  assign key_valid = valid_q;
  assign key_idx   = idx_q;
  assign keys      = keys_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed self-checking bench for tone_decoder with DIV=1 (one tick per clk).
module tb_tone_decoder;

  logic        clk;
  logic        rst_l;
  logic        tone_in;
  logic        key_valid;
  logic [3:0]  key_idx;
  logic [15:0] keys;
`ifdef TONE_DECODER_PERIOD_OUT_EN
  logic [10:0] half_period;
`endif

  int checks;
  int failures;

  tone_decoder #(
    .DIV       (1),
    .TOL       (4),
    .MATCH_CNT (4),
    .TIMEOUT   (1023)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .tone_in     (tone_in),
`ifdef TONE_DECODER_PERIOD_OUT_EN
    .half_period (half_period),
`endif
    .key_valid   (key_valid),
    .key_idx     (key_idx),
    .keys        (keys)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Toggle so that consecutive toggles are exactly h clocks apart, then let the edge settle.
  task automatic edge_h(input int h);
    repeat (h - 4) @(negedge clk);
    tone_in = ~tone_in;
    repeat (4) @(negedge clk);
  endtask

  task automatic edges(input int h, input int n);
    for (int i = 0; i < n; i++) edge_h(h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l   = 1'b0;
    tone_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] idx,
                           input logic [15:0] k);
    check_eq({tag, "_valid"}, 32'(key_valid), 32'(v));
    check_eq({tag, "_idx"}, 32'(key_idx), 32'(idx));
    check_eq({tag, "_keys"}, 32'(keys), 32'(k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_l    = 1'b0;
    tone_in  = 1'b0;
    repeat (3) @(negedge clk);
    check_out("reset", 1'b0, 4'd0, 16'h0000);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    // Key 0: first edge discarded, edges 2..5 match, lock on edge 5.
    edges(747, 4);
    check_out("k0_pre", 1'b0, 4'd0, 16'h0000);
    edge_h(747);
    check_out("k0_lock", 1'b1, 4'd0, 16'h0001);
    edge_h(747);
    check_out("k0_hold", 1'b1, 4'd0, 16'h0001);

    do_reset();
    edges(168, 5);
    check_out("k15", 1'b1, 4'd15, 16'h8000);
`ifdef TONE_DECODER_PERIOD_OUT_EN
    check_eq("hp_168", 32'(half_period), 32'd168);
`endif

    do_reset();
    edges(172, 8);
    check_eq("h172_nolock", 32'(key_valid), 32'd0);

    // Tolerance edge around T[0]=747.
    do_reset();
    edges(751, 5);
    check_out("h751", 1'b1, 4'd0, 16'h0001);
    do_reset();
    edges(752, 6);
    check_eq("h752_nolock", 32'(key_valid), 32'd0);

    // Timeout: lock key 8, hold tone_in; drop lands ~1023 clks after the last edge.
    do_reset();
    edges(332, 5);
    check_out("k8_lock", 1'b1, 4'd8, 16'h0100);
    repeat (1015) @(negedge clk);
    check_eq("k8_before_to", 32'(key_valid), 32'd1);
    repeat (15) @(negedge clk);
    check_out("k8_timeout", 1'b0, 4'd0, 16'h0000);

    // Key switch 3 -> 4: the first 471 half-period breaks lock, four matches relock.
    do_reset();
    edges(498, 5);
    check_out("k3_lock", 1'b1, 4'd3, 16'h0008);
    edge_h(471);
    check_out("sw_clear", 1'b0, 4'd0, 16'h0000);
    edges(471, 2);
    check_eq("sw_pre", 32'(key_valid), 32'd0);
    edge_h(471);
    check_out("k4_lock", 1'b1, 4'd4, 16'h0010);

    // Asynchronous reset mid-lock, then a full relock sequence.
    @(negedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 4'd0, 16'h0000);
    tone_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
    edges(264, 4);
    check_eq("rl_pre", 32'(key_valid), 32'd0);
    edge_h(264);
    check_out("k10_lock", 1'b1, 4'd10, 16'h0400);
`ifdef TONE_DECODER_PERIOD_OUT_EN
    check_eq("hp_264", 32'(half_period), 32'd264);
    edge_h(264);
    check_eq("hp_264b", 32'(half_period), 32'd264);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
